eth_send_test: RTL and testbench

- Self-contained GMII transmit test source that periodically emits a fixed Ethernet II broadcast ARP request frame.
- Generates preamble/SFD, header, ARP payload, zero padding and CRC32 FCS, one byte per clock.
- Sits directly in front of a GMII (or GMII-to-RGMII) PHY interface.
- Also drives the PHY reset pin.

---
 rtl/eth_send_test.sv | 132 +++++++++++++
 tb/tb_eth_send_test.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/eth_send_test.sv
// GMII transmit test source: periodically emits a fixed broadcast ARP request
// (preamble, header, payload, padding, CRC32 FCS), one byte per clock.
//
// state | meaning
// IDLE  | waiting for the interval counter to reach its last count
// SEND  | emitting frame bytes 0..71; idx holds the next byte to put out
module eth_send_test #(
  parameter logic [47:0] LOCAL_MAC     = 48'h000A3501FEC0,
  parameter logic [31:0] LOCAL_IP      = 32'hC0A80002,
  parameter logic [31:0] TARGET_IP     = 32'hC0A80003,
  parameter int          SEND_INTERVAL = 1250
) (
  input  logic       gmii_tx_clk,
  input  logic       rst_n,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic [7:0] gmii_tx_data,
  output logic       phy_rst_n
);

  localparam int                CNT_W    = $clog2(SEND_INTERVAL + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SEND_INTERVAL - 1);
  localparam logic [6:0]        LAST_IDX = 7'd72;

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [6:0]       idx;
  logic [31:0]      crc;
  logic [7:0]       byte_out;

  // Constant frame content for bytes 0..67; FCS bytes are handled separately.
  function automatic logic [7:0] frame_byte(input logic [6:0] i);
    logic [7:0] b;
    b = 8'h00;
    case (i)
      7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6: b = 8'h55;
      7'd7:                                     b = 8'hD5;
      7'd8, 7'd9, 7'd10, 7'd11, 7'd12, 7'd13:   b = 8'hFF;
      7'd14, 7'd30: b = LOCAL_MAC[47:40];
      7'd15, 7'd31: b = LOCAL_MAC[39:32];
      7'd16, 7'd32: b = LOCAL_MAC[31:24];
      7'd17, 7'd33: b = LOCAL_MAC[23:16];
      7'd18, 7'd34: b = LOCAL_MAC[15:8];
      7'd19, 7'd35: b = LOCAL_MAC[7:0];
      7'd20, 7'd24: b = 8'h08;
      7'd21:        b = 8'h06;
      7'd23, 7'd29: b = 8'h01;
      7'd26:        b = 8'h06;
      7'd27:        b = 8'h04;
      7'd36: b = LOCAL_IP[31:24];
      7'd37: b = LOCAL_IP[23:16];
      7'd38: b = LOCAL_IP[15:8];
      7'd39: b = LOCAL_IP[7:0];
      7'd46: b = TARGET_IP[31:24];
      7'd47: b = TARGET_IP[23:16];
      7'd48: b = TARGET_IP[15:8];
      7'd49: b = TARGET_IP[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Reflected CRC-32 (0xEDB88320 is 0x04C11DB7 bit-reversed), LSB of data first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  always_comb begin
    byte_out = frame_byte(idx);
    case (idx)
      7'd68: byte_out = ~crc[7:0];
      7'd69: byte_out = ~crc[15:8];
      7'd70: byte_out = ~crc[23:16];
      7'd71: byte_out = ~crc[31:24];
      default: ;
    endcase
  end

  assign gmii_tx_er = 1'b0;

  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      crc          <= '0;
      gmii_tx_en   <= 1'b0;
      gmii_tx_data <= 8'h00;
      phy_rst_n    <= 1'b0;
    end else begin
      phy_rst_n <= 1'b1;
      cnt       <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
      case (state)
        IDLE: begin
          gmii_tx_en   <= 1'b0;
          gmii_tx_data <= 8'h00;
          if (cnt == CNT_LAST) begin
            state        <= SEND;
            gmii_tx_en   <= 1'b1;
            gmii_tx_data <= frame_byte(7'd0);
            idx          <= 7'd1;
            crc          <= 32'hFFFFFFFF;
          end
        end
        SEND: begin
          if (idx == LAST_IDX) begin
            state        <= IDLE;
            gmii_tx_en   <= 1'b0;
            gmii_tx_data <= 8'h00;
            idx          <= '0;
          end else begin
            gmii_tx_en   <= 1'b1;
            gmii_tx_data <= byte_out;
            idx          <= idx + 7'd1;
            // FCS covers the header through the padding (bytes 8..67)
            if (idx >= 7'd8 && idx <= 7'd67) crc <= crc_byte(crc, byte_out);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_send_test.sv
// Bench for eth_send_test: frame model built from field values plus software
// CRC, cycle-by-cycle compare against the expected schedule, randomized resets.
module tb_eth_send_test;

  localparam int          SI    = 1250;
  localparam logic [47:0] MAC   = 48'h000A3501FEC0;
  localparam logic [31:0] IP_L  = 32'hC0A80002;
  localparam logic [31:0] IP_T  = 32'hC0A80003;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_en, tx_er, phy_rst_n;
  logic [7:0] tx_data;

  int checks = 0;
  int failures = 0;

  eth_send_test #(
    .LOCAL_MAC(MAC), .LOCAL_IP(IP_L), .TARGET_IP(IP_T), .SEND_INTERVAL(SI)
  ) dut (
    .gmii_tx_clk(clk), .rst_n(rst_n), .gmii_tx_en(tx_en), .gmii_tx_er(tx_er),
    .gmii_tx_data(tx_data), .phy_rst_n(phy_rst_n)
  );

  always #20 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] crc_sw(input logic [7:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i])
      for (int b = 0; b < 8; b++)
        c = ((c[0] ^ q[i][b]) != 1'b0) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  logic [7:0] model [72];
  bit         model_ready = 0;

  // edges since the last reset release
  int n;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) n <= 0;
    else        n <= n + 1;

  // cycle-by-cycle compare against the expected transmit schedule
  always @(negedge clk) begin
    if (model_ready) begin
      if (!rst_n) begin
        chk("rst_tx_en", 32'(tx_en), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_phy_rst_n", 32'(phy_rst_n), 32'd0);
      end else begin
        int  pos;
        bit  en;
        pos = (n >= SI) ? (n - SI) % SI : SI;
        en  = (pos < 72);
        chk("sched_tx_en", 32'(tx_en), 32'(en));
        chk("sched_tx_data", 32'(tx_data), en ? 32'(model[pos]) : 32'd0);
        chk("sched_phy_rst_n", 32'(phy_rst_n), 32'd1);
      end
      chk("tx_er", 32'(tx_er), 32'd0);
    end
  end

  // frame capture: length, content, residue, spacing of starts
  logic [7:0] cur[$];
  int frames = 0, cyc = 0, last_rise = 0, epoch = 0, rise_epoch = -1;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) cur.delete();
    else if (tx_en) begin
      if (cur.size() == 0) begin
        if (rise_epoch == epoch) chk("rise_gap", 32'(cyc - last_rise), 32'(SI));
        last_rise  = cyc;
        rise_epoch = epoch;
      end
      cur.push_back(tx_data);
    end else if (cur.size() > 0) begin
      chk("frame_len", 32'(cur.size()), 32'd72);
      if (cur.size() == 72) begin
        int mism;
        logic [7:0] q[$];
        mism = 0;
        for (int i = 0; i < 72; i++) if (cur[i] !== model[i]) mism++;
        chk("frame_bytes", 32'(mism), 32'd0);
        q = cur[8:71];
        chk("frame_residue", bitrev32(crc_sw(q)), 32'hC704DD7B);
      end
      frames++;
      cur.delete();
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] lit [60];
    logic [7:0] q[$];
    logic [31:0] c;
    int mism, target, hold, f0, f_first;
    bit found;

    // model assembled from the frame fields
    for (int i = 0; i < 7; i++) model[i] = 8'h55;
    model[7] = 8'hD5;
    for (int i = 8; i < 14; i++) model[i] = 8'hFF;
    for (int k = 0; k < 6; k++) begin
      model[14+k] = 8'(MAC >> (8 * (5 - k)));
      model[30+k] = 8'(MAC >> (8 * (5 - k)));
      model[40+k] = 8'h00;
    end
    model[20] = 8'h08; model[21] = 8'h06; model[22] = 8'h00; model[23] = 8'h01;
    model[24] = 8'h08; model[25] = 8'h00; model[26] = 8'h06; model[27] = 8'h04;
    model[28] = 8'h00; model[29] = 8'h01;
    for (int k = 0; k < 4; k++) begin
      model[36+k] = 8'(IP_L >> (8 * (3 - k)));
      model[46+k] = 8'(IP_T >> (8 * (3 - k)));
    end
    for (int i = 50; i < 68; i++) model[i] = 8'h00;
    for (int i = 8; i < 68; i++) q.push_back(model[i]);
    c = ~crc_sw(q);
    for (int k = 0; k < 4; k++) model[68+k] = 8'(c >> (8 * k));

    // pin the model against hand-written bytes and the known residue
    lit = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
            8'h00, 8'h0A, 8'h35, 8'h01, 8'hFE, 8'hC0, 8'h08, 8'h06,
            8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
            8'h00, 8'h0A, 8'h35, 8'h01, 8'hFE, 8'hC0, 8'hC0, 8'hA8, 8'h00, 8'h02,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC0, 8'hA8, 8'h00, 8'h03,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    mism = 0;
    for (int i = 0; i < 60; i++) if (model[8+i] !== lit[i]) mism++;
    chk("model_header", 32'(mism), 32'd0);
    chk("model_sfd", 32'(model[7]), 32'hD5);
    for (int i = 68; i < 72; i++) q.push_back(model[i]);
    chk("model_residue", bitrev32(crc_sw(q)), 32'hC704DD7B);
    model_ready = 1;

    // power-on reset for 201 ns
    #200;
    chk("por_phy_rst_n", 32'(phy_rst_n), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("release_phy_rst_n", 32'(phy_rst_n), 32'd1);
    repeat (SI - 2) @(posedge clk);
    #1 chk("pre_first_tx_en", 32'(tx_en), 32'd0);
    @(posedge clk); #1;
    chk("first_tx_en", 32'(tx_en), 32'd1);
    chk("first_byte", 32'(tx_data), 32'h55);

    repeat (5000 - SI) @(posedge clk);
    f_first = frames;
    chk("frames_in_200us", 32'(f_first >= 3), 32'd1);

    // resets landing mid-frame, first at byte 30 then at random bytes
    for (int t = 0; t < 3; t++) begin
      target = (t == 0) ? 30 : int'($urandom_range(0, 71));
      found = 0;
      for (int k = 0; k < 3 * SI && !found; k++) begin
        @(posedge clk); #1;
        if (n >= SI && (n - SI) % SI == target) found = 1;
      end
      chk("reach_byte", 32'(found), 32'd1);
      #4;
      epoch++;
      rst_n = 1'b0;
      #1;
      chk("abort_tx_en", 32'(tx_en), 32'd0);
      chk("abort_tx_data", 32'(tx_data), 32'd0);
      hold = int'($urandom_range(1, 4));
      repeat (hold) @(negedge clk);
      #1 rst_n = 1'b1;
      f0 = frames;
      repeat (SI + 72 + 10) @(posedge clk);
      chk("frame_after_reset", 32'(frames - f0), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
